// File: rtl/fpu_mul_scheduler.sv
// fpu_mul_scheduler: round-robin sharing of one pipelined FP32 multiplier
// among NUM_REQ requesters (FFT butterfly/twiddle stages).
// Handshake: requester k transfers an operand pair in any cycle where
// i_req_valid[k] && o_req_ready[k]. At most one ready bit is high per cycle,
// and ready never depends on ready. Responses (o_rsp_valid one-hot) carry no
// backpressure and return in issue order.
module fpu_mul_scheduler #(
   parameter int SIZE_DATA   = 32,
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 3,
   parameter int MAX_OUT     = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_a,
   input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_b,
   output logic                          o_mul_valid,
   output logic [SIZE_DATA-1:0]          o_mul_a,
   output logic [SIZE_DATA-1:0]          o_mul_b,
   input  logic [SIZE_DATA-1:0]          i_mul_result,
   output logic [NUM_REQ-1:0]            o_rsp_valid,
   output logic [SIZE_DATA-1:0]          o_rsp_data,
   output logic                          o_busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CRD_W = $clog2(MAX_OUT + 1);
   localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(MAX_OUT);
   localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0]     ptr;
   logic [CRD_W-1:0]     credit [NUM_REQ];
   logic [NUM_REQ-1:0]   eligible;
   logic [SIZE_DATA-1:0] req_a [NUM_REQ];
   logic [SIZE_DATA-1:0] req_b [NUM_REQ];

   logic                 grant_any;
   logic [PTR_W-1:0]     grant_idx;
   logic [NUM_REQ-1:0]   grant_vec;
   logic [PTR_W:0]       scan_sum;
   logic [PTR_W-1:0]     scan_idx;

   // Stage 0 runs alongside o_mul_valid; stages 1..MUL_LATENCY track the
   // multiplier, so the last stage lines up with i_mul_result.
   logic                 tag_vld [MUL_LATENCY+1];
   logic [PTR_W-1:0]     tag_id  [MUL_LATENCY+1];
   logic                 ret_vld;
   logic [PTR_W-1:0]     ret_id;
   logic [NUM_REQ-1:0]   ret_onehot;

   // Unpack per-requester operands and qualify requests with their credit.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
      assign req_a[k]    = i_req_a[k*SIZE_DATA +: SIZE_DATA];
      assign req_b[k]    = i_req_b[k*SIZE_DATA +: SIZE_DATA];
      assign eligible[k] = i_req_valid[k] && (credit[k] < CRD_MAX);

`ifndef SYNTHESIS
      // A waiting (valid, not granted) requester must hold its operands.
      a_hold_operands : assert property (
         @(posedge i_clk) disable iff (!i_rst_n)
         (i_req_valid[k] && !o_req_ready[k]) |=>
            (!i_req_valid[k] ||
             ($stable(i_req_a[k*SIZE_DATA +: SIZE_DATA]) &&
              $stable(i_req_b[k*SIZE_DATA +: SIZE_DATA]))));
`endif
   end

   // Round-robin search: first eligible requester starting at ptr.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      grant_vec = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, ptr} + (PTR_W+1)'(i);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (!grant_any && eligible[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (grant_any) begin
         grant_vec[grant_idx] = 1'b1;
      end
   end

   assign o_req_ready = i_rst_n ? grant_vec : '0;

   // Issue register: capture the granted operands and advance the pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr         <= '0;
         o_mul_valid <= 1'b0;
         o_mul_a     <= '0;
         o_mul_b     <= '0;
      end else begin
         o_mul_valid <= grant_any;
         if (grant_any) begin
            o_mul_a <= req_a[grant_idx];
            o_mul_b <= req_b[grant_idx];
            ptr     <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Tag pipeline: free-running shift of {valid, requester id}.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i <= MUL_LATENCY; i++) begin
            tag_vld[i] <= 1'b0;
            tag_id[i]  <= '0;
         end
      end else begin
         tag_vld[0] <= grant_any;
         tag_id[0]  <= grant_idx;
         for (int i = 1; i <= MUL_LATENCY; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
      end
   end

   assign ret_vld = tag_vld[MUL_LATENCY];
   assign ret_id  = tag_id[MUL_LATENCY];

   // Decode the returning tag into a one-hot requester strobe.
   always_comb begin
      ret_onehot         = '0;
      ret_onehot[ret_id] = ret_vld;
   end

   // Response register: route the multiplier result to its requester.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rsp_valid <= '0;
         o_rsp_data  <= '0;
      end else begin
         o_rsp_valid <= ret_onehot;
         if (ret_vld) begin
            o_rsp_data <= i_mul_result;
         end
      end
   end

   // Credit counters: +1 on issue, -1 as the response is loaded; both cancel.
   // Eligibility keeps them at or below MAX_OUT, and only issued tags return.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            credit[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            case ({grant_vec[k], ret_onehot[k]})
               2'b10:   credit[k] <= credit[k] + 1'b1;
               2'b01:   credit[k] <= credit[k] - 1'b1;
               default: credit[k] <= credit[k];
            endcase
         end
      end
   end

   // Busy whenever any requester still has work outstanding.
   always_comb begin
      o_busy = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (credit[k] != '0) begin
            o_busy = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Testbench for fpu_mul_scheduler with a stand-in 3-cycle FP32 multiplier.
module tb_fpu_mul_scheduler;

   localparam int SD = 32;
   localparam int NR = 4;
   localparam int ML = 3;
   localparam int MO = 2;

   // Fixed operand pairs per requester and their hand-computed products.
   // req0: 1.0*5.0=5.0  req1: 2.0*3.0=6.0  req2: 3.0*4.0=12.0  req3: -0.5*4.0=-2.0
   localparam logic [31:0] OPA  [NR] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF000000};
   localparam logic [31:0] OPB  [NR] = '{32'h40A00000, 32'h40400000, 32'h40800000, 32'h40800000};
   localparam logic [31:0] PROD [NR] = '{32'h40A00000, 32'h40C00000, 32'h41400000, 32'hC0000000};

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic [NR-1:0]        i_req_valid;
   logic [NR-1:0]        o_req_ready;
   logic [NR*SD-1:0]     i_req_a;
   logic [NR*SD-1:0]     i_req_b;
   logic                 o_mul_valid;
   logic [SD-1:0]        o_mul_a;
   logic [SD-1:0]        o_mul_b;
   logic [SD-1:0]        i_mul_result;
   logic [NR-1:0]        o_rsp_valid;
   logic [SD-1:0]        o_rsp_data;
   logic                 o_busy;

   int n_chk  = 0;
   int n_pass = 0;
   logic [35:0] exp_q[$];

   // Clock
   always #5 i_clk = ~i_clk;

   fpu_mul_scheduler #(
      .SIZE_DATA  (SD),
      .NUM_REQ    (NR),
      .MUL_LATENCY(ML),
      .MAX_OUT    (MO)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_a     (i_req_a),
      .i_req_b     (i_req_b),
      .o_mul_valid (o_mul_valid),
      .o_mul_a     (o_mul_a),
      .o_mul_b     (o_mul_b),
      .i_mul_result(i_mul_result),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_data  (o_rsp_data),
      .o_busy      (o_busy)
   );

   // Truncating FP32 multiply for normal operands (stand-in datapath).
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [9:0]  e;
      logic [47:0] m;
      s = a[31] ^ b[31];
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (m[47]) begin
         e = e + 10'd1;
         return {s, e[7:0], m[46:24]};
      end
      return {s, e[7:0], m[45:23]};
   endfunction

   // Multiplier model: result appears ML cycles after the issue cycle.
   logic [31:0] mpipe [ML];
   always @(posedge i_clk) begin
      mpipe[0] <= o_mul_valid ? fmul(o_mul_a, o_mul_b) : 32'h0;
      for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
   end
   assign i_mul_result = mpipe[ML-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Advance to the next cycle, drive valid, let combinational ready settle.
   task automatic drive(input logic [NR-1:0] v);
      @(negedge i_clk);
      i_req_valid = v;
      #1;
   endtask

   task automatic reset_dut();
      @(negedge i_clk);
      i_req_valid = '0;
      i_rst_n     = 1'b0;
      @(negedge i_clk);
      i_rst_n     = 1'b1;
   endtask

   initial begin
      logic [10:0]   rdy_pat;
      logic [10:0]   rsp_pat;
      logic [35:0]   e;
      logic [NR-1:0] t6_rsp [4];
      logic [31:0]   t6_dat [4];

      i_rst_n     = 1'b0;
      i_req_valid = '0;
      for (int k = 0; k < NR; k++) begin
         i_req_a[k*SD +: SD] = OPA[k];
         i_req_b[k*SD +: SD] = OPB[k];
      end

      // Reset state, with requests presented during reset
      drive(4'hF);
      check("rst_ready",    o_req_ready, 4'h0);
      check("rst_mul_valid", o_mul_valid, 1'b0);
      check("rst_mul_a",    o_mul_a, 32'h0);
      check("rst_mul_b",    o_mul_b, 32'h0);
      check("rst_rsp_valid", o_rsp_valid, 4'h0);
      check("rst_rsp_data", o_rsp_data, 32'h0);
      check("rst_busy",     o_busy, 1'b0);
      @(negedge i_clk);
      i_req_valid = '0;
      i_rst_n     = 1'b1;

      // 1: single requester, 2.0 * 3.0 on req1
      drive(4'b0010);
      check("t1_ready", o_req_ready, 4'b0010);
      drive(4'b0000);
      check("t1_mul_valid", o_mul_valid, 1'b1);
      check("t1_mul_a", o_mul_a, 32'h40000000);
      check("t1_mul_b", o_mul_b, 32'h40400000);
      check("t1_busy_on", o_busy, 1'b1);
      for (int c = 2; c <= 4; c++) begin
         drive(4'b0000);
         check("t1_rsp_idle", o_rsp_valid, 4'b0000);
      end
      drive(4'b0000);
      check("t1_rsp_valid", o_rsp_valid, 4'b0010);
      check("t1_rsp_data", o_rsp_data, 32'h40C00000);
      check("t1_busy_off", o_busy, 1'b0);
      drive(4'b0000);
      check("t1_rsp_drop", o_rsp_valid, 4'b0000);
      check("t1_data_hold", o_rsp_data, 32'h40C00000);

      // 2: all four valid, round-robin grants and in-order responses
      reset_dut();
      for (int c = 0; c <= 12; c++) begin
         drive((c < 8) ? 4'hF : 4'h0);
         check("t2_ready", o_req_ready, (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
         if (c < 8) exp_q.push_back({4'b0001 << (c % 4), PROD[c % 4]});
         if (c >= 5) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("t2_rsp", {o_rsp_valid, o_rsp_data}, e);
            end else begin
               check("t2_q_empty", 1'b1, 1'b0);
            end
         end else begin
            check("t2_rsp_idle", o_rsp_valid, 4'b0000);
         end
      end
      check("t2_q_drained", exp_q.size(), 0);

      // 3: credit cap on req2 alone
      reset_dut();
      rdy_pat = 11'b10001100011;
      rsp_pat = 11'b10001100000;
      for (int c = 0; c <= 10; c++) begin
         drive(4'b0100);
         check("t3_ready", o_req_ready, rdy_pat[c] ? 4'b0100 : 4'b0000);
         check("t3_rsp", o_rsp_valid, rsp_pat[c] ? 4'b0100 : 4'b0000);
      end

      // 4: response and new grant to req0 on the same edge at credit 1
      reset_dut();
      drive(4'b0001);
      check("t4_ready0", o_req_ready, 4'b0001);
      for (int c = 1; c <= 3; c++) drive(4'b0000);
      drive(4'b0001);
      check("t4_ready4", o_req_ready, 4'b0001);
      drive(4'b0001);
      check("t4_ready5", o_req_ready, 4'b0001);
      check("t4_rsp5", o_rsp_valid, 4'b0001);
      check("t4_data5", o_rsp_data, 32'h40A00000);
      check("t4_mul5", o_mul_valid, 1'b1);
      drive(4'b0001);
      check("t4_ready6_capped", o_req_ready, 4'b0000);
      drive(4'b0000);
      drive(4'b0000);
      check("t4_rsp8", o_rsp_valid, 4'b0000);
      drive(4'b0000);
      check("t4_rsp9", o_rsp_valid, 4'b0001);
      check("t4_data9", o_rsp_data, 32'h40A00000);
      drive(4'b0000);
      check("t4_rsp10", o_rsp_valid, 4'b0001);
      drive(4'b0000);

      // 5: asynchronous reset with three operations in flight (ptr starts at 1)
      drive(4'b0111);
      check("t5_ready0", o_req_ready, 4'b0010);
      drive(4'b0101);
      check("t5_ready1", o_req_ready, 4'b0100);
      drive(4'b0001);
      check("t5_ready2", o_req_ready, 4'b0001);
      drive(4'b0000);
      check("t5_pre_mul", o_mul_valid, 1'b1);
      check("t5_pre_busy", o_busy, 1'b1);
      i_rst_n     = 1'b0;
      i_req_valid = 4'b0001;
      #1;
      check("t5_ready", o_req_ready, 4'b0000);
      check("t5_mul_valid", o_mul_valid, 1'b0);
      check("t5_mul_a", o_mul_a, 32'h0);
      check("t5_mul_b", o_mul_b, 32'h0);
      check("t5_rsp_valid", o_rsp_valid, 4'b0000);
      check("t5_rsp_data", o_rsp_data, 32'h0);
      check("t5_busy", o_busy, 1'b0);
      @(negedge i_clk);
      i_rst_n     = 1'b1;
      i_req_valid = '0;
      for (int c = 0; c < 10; c++) begin
         drive(4'b0000);
         check("t5_no_stray", o_rsp_valid, 4'b0000);
      end
      drive(4'b1111);
      check("t5_ptr_zero", o_req_ready, 4'b0001);

      // 6: pointer wrap after a grant to req3
      reset_dut();
      t6_rsp = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
      t6_dat = '{PROD[2], PROD[3], PROD[0], PROD[2]};
      drive(4'b0100);
      check("t6_ready0", o_req_ready, 4'b0100);
      drive(4'b1000);
      check("t6_ready1", o_req_ready, 4'b1000);
      drive(4'b0101);
      check("t6_wrap", o_req_ready, 4'b0001);
      drive(4'b0100);
      check("t6_next", o_req_ready, 4'b0100);
      drive(4'b0000);
      for (int i = 0; i < 4; i++) begin
         drive(4'b0000);
         check("t6_rsp", o_rsp_valid, t6_rsp[i]);
         check("t6_data", o_rsp_data, t6_dat[i]);
      end
      drive(4'b0000);
      check("t6_idle", o_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fpu_mul_scheduler.md
Name: fpu_mul_scheduler

Overview:
- Round-robin scheduler that shares one fixed-latency pipelined FP32 multiplier (FPU_MUL datapath) among NUM_REQ requesters.
- Requesters are the butterfly/twiddle stages of the 8-point FFT.
- Accepts operand pairs by valid/ready and issues at most one multiply per cycle.
- Tracks each in-flight operation's requester tag through a latency-matched shift register, routes results back, and caps outstanding operations per requester with a credit counter.

Parameters:
- SIZE_DATA, 32, operand/result width (IEEE-754 single).
- NUM_REQ, 4, number of requesters (>=2).
- MUL_LATENCY, 3, multiplier cycles from sampled o_mul_valid to result on i_mul_result (>=1).
- MAX_OUT, 2, maximum outstanding operations per requester (>=1).

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, reset: asynchronous, active-low.
- i_req_valid, input, NUM_REQ, per-requester operand-pair valid.
- o_req_ready, output, NUM_REQ, per-requester grant/ready (one-hot or zero).
- i_req_a, input, NUM_REQ*SIZE_DATA, operand A, requester k at [k*SIZE_DATA +: SIZE_DATA].
- i_req_b, input, NUM_REQ*SIZE_DATA, operand B, same packing.
- o_mul_valid, output, 1, issue strobe to multiplier.
- o_mul_a, output, SIZE_DATA, operand A to multiplier.
- o_mul_b, output, SIZE_DATA, operand B to multiplier.
- i_mul_result, input, SIZE_DATA, multiplier result.
- o_rsp_valid, output, NUM_REQ, one-hot result strobe.
- o_rsp_data, output, SIZE_DATA, result data.
- o_busy, output, 1, any operation in flight.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: o_mul_valid=0, o_mul_a=0, o_mul_b=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, RR pointer=0, all credit counters=0, tag pipeline valid bits=0.
- o_req_ready is combinational; it is 0 whenever reset is asserted.
- Eligibility: requester k is eligible when i_req_valid[k]=1 and credit[k] < MAX_OUT.
- Grant: combinational. The first eligible requester searching ptr, ptr+1, ... (mod NUM_REQ) gets o_req_ready[k]=1. All other ready bits are 0.
  - o_req_ready never depends on ready from the same cycle (no loop).
- Handshake: a transfer occurs when i_req_valid[k] & o_req_ready[k]. At that edge:
  - o_mul_a/o_mul_b are loaded from slot k and o_mul_valid is set to 1.
  - Tag pipeline stage 0 loads {valid=1, tag=k}.
  - ptr is set to (k+1) mod NUM_REQ.
- No transfer: o_mul_valid=0, stage-0 valid=0, ptr unchanged, o_mul_a/b hold their last values.
- Tag pipeline: MUL_LATENCY stages, advanced every cycle with no stall. Its final stage aligns with i_mul_result for the operation issued in cycle t (result in cycle t+MUL_LATENCY).
- Response: registered.
  - Final stage valid: o_rsp_valid = onehot(tag), o_rsp_data = i_mul_result on the next edge.
  - Otherwise o_rsp_valid=0 and o_rsp_data holds.
- Latency: handshake edge c -> o_mul_valid high in cycle c+1 -> result in cycle c+1+MUL_LATENCY -> o_rsp_valid high in cycle c+2+MUL_LATENCY. For MUL_LATENCY=3 that is 5 cycles after the handshake.
- Responses have no backpressure; the requester must accept o_rsp_valid.
- Ordering: results return in issue order globally and per requester.
- Credits:
  - credit[k] increments on a handshake for k.
  - credit[k] decrements in the cycle o_rsp_valid[k] is loaded.
  - Simultaneous increment and decrement on the same k leaves it unchanged.
  - A counter never exceeds MAX_OUT and never goes below 0.
  - Counter width is clog2(MAX_OUT+1).
- Credit release timing: a requester at MAX_OUT becomes eligible again on the cycle after its o_rsp_valid edge (credit is registered).
- o_busy: 1 when any credit[k] != 0. It is registered-derived, so no combinational path from inputs.
- Throughput: one issue per cycle sustained when at least one requester is eligible.
- Wrap-around: ptr wraps NUM_REQ-1 -> 0.
- Reset mid-operation:
  - All tag-pipeline valids, credits and ptr clear immediately.
  - Multiplier results still in flight are ignored; no o_rsp_valid is ever produced for them.
- i_req_a/b must stay stable while i_req_valid=1 and not yet granted (requester obligation, checked by assertion).

Test Plan:
1. Single requester (N=4, L=3, MAX_OUT=2): req1 valid, a=0x40000000 (2.0), b=0x40400000 (3.0), model returns product. Expect o_req_ready=4'b0010 in the same cycle, o_mul_valid one cycle later, o_rsp_valid=4'b0010 with o_rsp_data=0x40C00000 (6.0) 5 cycles after the handshake, o_busy 1 then 0.
2. All four valid continuously. Expect grants 0,1,2,3,0,... (one per cycle) and responses in the same order.
3. Credit cap: only req2 valid every cycle. Expect 2 grants, then ready=0 until its first response edge, grant again the next cycle; credit never exceeds 2.
4. Simultaneous response and new grant to req0 at credit=1. Expect credit to stay 1 and the issue to proceed.
5. Assert i_rst_n=0 asynchronously with 3 operations in flight. Expect all outputs 0 immediately; after release, no stray o_rsp_valid for 10 cycles and ptr=0 (req0 wins the first grant).
6. Pointer wrap: after a grant to req3 with req0 and req2 valid. Expect req0 granted next, then req2.
